alu_dispatch: RTL and testbench
===============================

Name: alu_dispatch

Overview:
- Command front-end for the ALU execution units (arithmetic, logic, compare, shift).
- Accepts one operation at a time over a valid/ready request channel and decodes alu_fun[3:2] into a one-cycle unit enable.
- Drives the shared operand bus to all units, waits for the selected unit's registered result and flag, then returns the result over a valid/ready response channel.
- Sits between the instruction/control path and the unit bank.

Parameters:
- WIDTH, 16, operand and result width; must match the units.
- TIMEOUT, 4, maximum wait cycles for the unit flag before an error response; legal range 2..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  dispatcher can accept a request
- req_fun  in  4  operation code; [3:2] selects unit: 00 arith, 01 logic, 10 cmp, 11 shift
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- alu_fun  out  4  function code driven to all units
- a  out  WIDTH  operand A to all units
- b  out  WIDTH  operand B to all units
- ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN  out  1 each  unit enables, one-hot or all zero
- arith_out, logic_out, cmp_out, shift_out  in  WIDTH each  registered unit results
- arith_flag, logic_flag, cmp_flag, shift_flag  in  1 each  registered unit result-valid flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  captured result
- rsp_fun  out  4  echo of the request's function code
- rsp_err  out  1  unit failed to flag within TIMEOUT cycles

Behaviour:
- Reset values: all outputs 0; state IDLE. Asserting rst mid-operation aborts the operation with no response. After rst releases, req_ready is 1 in the first cycle.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register req_fun, req_a, req_b into the alu_fun/a/b outputs, then go to ISSUE.
- ISSUE (exactly 1 cycle): assert exactly one enable, decoded from alu_fun[3:2]. Clear the wait counter. Go to WAIT.
- WAIT: all enables 0; alu_fun/a/b held unchanged.
  - Each cycle, sample the selected unit's flag.
  - If the flag is 1: rsp_data = selected unit output, rsp_err = 0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with the flag still 0: rsp_data = 0, rsp_err = 1, go to RESP.
  - Flags and outputs of unselected units are ignored.
- RESP: rsp_valid=1. rsp_data, rsp_fun and rsp_err stay stable until rsp_ready=1, then go to IDLE and clear rsp_valid.
- req_ready is 0 in every state except IDLE; no request is accepted in the handoff cycle.
- Latency for a compliant unit (flag in the first WAIT cycle): request accepted at edge N, enable high in cycle N+1, rsp_valid high from edge N+3.
- The response registers and the echoed function code are loaded only on the WAIT->RESP transition.
- Widths: no arithmetic on data; the counter is 4 bits. TIMEOUT is checked at elaboration.

Decomposition:
- Shared package alu_pkg holds:
  - unit-select codes UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11;
  - compare function codes EQ=2'b01, GT=2'b10, LT=2'b11;
  - the dispatcher state encoding.
- One sub-module, alu_unit_mux: a combinational 4:1 selection of {out, flag} by unit code, reused by the WAIT-state capture.

Test Plan:
- Compare equal: req_fun=4'b1001, a=16'h0005, b=16'h0005 with a CMP unit model attached -> CMP_EN high for one cycle only, rsp_data=16'h0001, rsp_err=0, rsp_fun=4'b1001, rsp_valid asserted 3 edges after acceptance.
- Compare greater then less, back-to-back: fun 4'b1010 with a=7, b=3 gives rsp_data=2; then fun 4'b1011 with a=3, b=7 gives rsp_data=3. The second request is accepted only after the first response handshake.
- Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid rises -> rsp_data/rsp_err/rsp_fun stable, req_ready=0, all enables 0 throughout. The handshake completes on the cycle rsp_ready rises.
- Timeout: shift unit stub never asserts its flag, fun 4'b1100 -> SHIFT_EN pulses once, rsp_valid rises after exactly TIMEOUT=4 WAIT cycles with rsp_err=1 and rsp_data=0.
- Unselected noise: arith_flag=1 and arith_out=16'hFFFF held constantly during a CMP op with a=2, b=2 -> response is 16'h0001 from the compare unit, not 16'hFFFF.
- Reset mid-operation: assert rst during WAIT -> enables, rsp_valid, alu_fun, a and b go 0 immediately. After release, req_ready=1 and no stale response is ever presented.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatcher and its unit bank:
// unit-select codes, compare function codes and dispatcher state encoding.
package alu_pkg;

    // alu_fun[3:2] selects the execution unit
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    // alu_fun[1:0] for the compare unit
    localparam logic [1:0] EQ = 2'b01;
    localparam logic [1:0] GT = 2'b10;
    localparam logic [1:0] LT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } disp_state_e;

    // One-hot enable vector, bit index == unit code
    function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/alu_dispatch_unit_mux.sv
// Combinational 4:1 selection of a unit's {result, flag} by unit code.
module alu_unit_mux
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] arith_out,
    input  logic [WIDTH-1:0] logic_out,
    input  logic [WIDTH-1:0] cmp_out,
    input  logic [WIDTH-1:0] shift_out,
    input  logic             arith_flag,
    input  logic             logic_flag,
    input  logic             cmp_flag,
    input  logic             shift_flag,
    output logic [WIDTH-1:0] out,
    output logic             flag
);

    // Route only the selected unit; everything else is ignored
    always_comb begin
        out  = arith_out;
        flag = arith_flag;
        case (sel)
            UNIT_ARITH: begin out = arith_out; flag = arith_flag; end
            UNIT_LOGIC: begin out = logic_out; flag = logic_flag; end
            UNIT_CMP:   begin out = cmp_out;   flag = cmp_flag;   end
            UNIT_SHIFT: begin out = shift_out; flag = shift_flag; end
            default:    begin out = arith_out; flag = arith_flag; end
        endcase
    end

endmodule

// File: rtl/alu_dispatch.sv
// Command front-end for the ALU unit bank. Accepts one operation over a
// valid/ready request channel, pulses the selected unit's enable once,
// waits (bounded) for that unit's registered flag and returns the result
// over a valid/ready response channel.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both 1; the sender holds its payload stable while
// valid is 1 and ready is 0, and valid never drops before the transfer.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_fun,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       alu_fun,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             ARITH_EN,
    output logic             LOGIC_EN,
    output logic             CMP_EN,
    output logic             SHIFT_EN,
    input  logic [WIDTH-1:0] arith_out,
    input  logic [WIDTH-1:0] logic_out,
    input  logic [WIDTH-1:0] cmp_out,
    input  logic [WIDTH-1:0] shift_out,
    input  logic             arith_flag,
    input  logic             logic_flag,
    input  logic             cmp_flag,
    input  logic             shift_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_fun,
    output logic             rsp_err
);

    if (TIMEOUT < 2 || TIMEOUT > 15) begin : g_bad_timeout
        $error("alu_dispatch: TIMEOUT must be in 2..15");
    end

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    disp_state_e      state_q, state_d;
    logic [3:0]       alu_fun_q, alu_fun_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       en_q, en_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]       rsp_fun_q, rsp_fun_d;
    logic             rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0] sel_out;
    logic             sel_flag;

    alu_unit_mux #(.WIDTH(WIDTH)) u_mux (
        .sel        (alu_fun_q[3:2]),
        .arith_out  (arith_out),
        .logic_out  (logic_out),
        .cmp_out    (cmp_out),
        .shift_out  (shift_out),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag),
        .out        (sel_out),
        .flag       (sel_flag)
    );

    // Next-state and registered-output computation for the dispatcher FSM
    always_comb begin
        state_d     = state_q;
        alu_fun_d   = alu_fun_q;
        a_d         = a_q;
        b_d         = b_q;
        en_d        = 4'b0000;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fun_d   = rsp_fun_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_fun_d = req_fun;
                    a_d       = req_a;
                    b_d       = req_b;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Enable is registered, so it is visible for exactly one cycle
                en_d    = unit_onehot(alu_fun_q[3:2]);
                cnt_d   = 4'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sel_flag) begin
                    rsp_data_d  = sel_out;
                    rsp_err_d   = 1'b0;
                    rsp_fun_d   = alu_fun_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_fun_d   = alu_fun_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_fun_q   <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            en_q        <= 4'd0;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fun_q   <= 4'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_fun_q   <= alu_fun_d;
            a_q         <= a_d;
            b_q         <= b_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fun_q   <= rsp_fun_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Held low while rst is asserted so every output reads 0 in reset
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign alu_fun   = alu_fun_q;
    assign a         = a_q;
    assign b         = b_q;
    assign ARITH_EN  = en_q[UNIT_ARITH];
    assign LOGIC_EN  = en_q[UNIT_LOGIC];
    assign CMP_EN    = en_q[UNIT_CMP];
    assign SHIFT_EN  = en_q[UNIT_SHIFT];
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_fun   = rsp_fun_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: behavioural unit bank, request driver,
// response backpressure driver, scoreboard monitor, directed + random phases.
module tb_alu_dispatch;
    import alu_pkg::*;

    localparam int W   = 16;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_fun = 4'd0;
    logic [W-1:0] req_a = '0, req_b = '0;
    logic [3:0]   alu_fun;
    logic [W-1:0] a, b;
    logic         ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;
    logic [W-1:0] arith_out, logic_out, cmp_out, shift_out;
    logic         arith_flag, logic_flag, cmp_flag, shift_flag;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_fun;
    logic         rsp_err;

    alu_dispatch #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_fun(req_fun),
        .req_a(req_a), .req_b(req_b),
        .alu_fun(alu_fun), .a(a), .b(b),
        .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
        .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
        .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_fun(rsp_fun), .rsp_err(rsp_err)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // What each unit computes for a given function code
    function automatic logic [W-1:0] ref_result(input logic [3:0] fun, input logic [W-1:0] x, input logic [W-1:0] y);
        case (fun[3:2])
            UNIT_ARITH: case (fun[1:0])
                2'b00: return x + y;
                2'b01: return x - y;
                2'b10: return x + 16'd1;
                default: return x - 16'd1;
            endcase
            UNIT_LOGIC: case (fun[1:0])
                2'b00: return x & y;
                2'b01: return x | y;
                2'b10: return x ^ y;
                default: return ~x;
            endcase
            UNIT_CMP: case (fun[1:0])
                EQ: return (x == y) ? 16'd1 : 16'd0;
                GT: return (x > y)  ? 16'd2 : 16'd0;
                LT: return (x < y)  ? 16'd3 : 16'd0;
                default: return 16'd0;
            endcase
            default: case (fun[1:0])
                2'b00: return x << y[3:0];
                2'b01: return x >> y[3:0];
                2'b10: return {x[14:0], x[15]};
                default: return {x[0], x[15:1]};
            endcase
        endcase
    endfunction

    // ---------------- behavioural unit bank ----------------
    logic         arith_noise = 1'b0;
    logic         shift_dead  = 1'b0;
    logic [W-1:0] arith_m, logic_m, cmp_m, shift_m;
    logic         arith_fm, logic_fm, cmp_fm, shift_fm;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arith_m <= 16'h1111; logic_m <= 16'h2222; cmp_m <= 16'h3333; shift_m <= 16'h4444;
            arith_fm <= 1'b0; logic_fm <= 1'b0; cmp_fm <= 1'b0; shift_fm <= 1'b0;
        end else begin
            arith_fm <= ARITH_EN;
            logic_fm <= LOGIC_EN;
            cmp_fm   <= CMP_EN;
            shift_fm <= SHIFT_EN;
            if (ARITH_EN) arith_m <= ref_result({UNIT_ARITH, alu_fun[1:0]}, a, b);
            if (LOGIC_EN) logic_m <= ref_result({UNIT_LOGIC, alu_fun[1:0]}, a, b);
            if (CMP_EN)   cmp_m   <= ref_result({UNIT_CMP,   alu_fun[1:0]}, a, b);
            if (SHIFT_EN) shift_m <= ref_result({UNIT_SHIFT, alu_fun[1:0]}, a, b);
        end
    end

    assign arith_out  = arith_noise ? 16'hFFFF : arith_m;
    assign arith_flag = arith_noise | arith_fm;
    assign logic_out  = logic_m;
    assign logic_flag = logic_fm;
    assign cmp_out    = cmp_m;
    assign cmp_flag   = cmp_fm;
    assign shift_out  = shift_m;
    assign shift_flag = shift_dead ? 1'b0 : shift_fm;

    // ---------------- response backpressure driver ----------------
    int bp_cycles = 0;
    int hold = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            hold = 0; rsp_ready = 1'b0;
        end else if (rsp_valid) begin
            if (hold >= bp_cycles) rsp_ready = 1'b1;
            else begin rsp_ready = 1'b0; hold++; end
        end else begin
            hold = 0; rsp_ready = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [20:0] exp_q[$];   // {err, fun, data}
    int          acc_q[$];   // cycle of the accepting edge
    int          lat_q[$];   // expected edges from accept to rsp_valid

    task automatic send(input logic [3:0] fun, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        logic         e;
        int           lat;
        bit           ok;
        ok = 0;
        if (fun[3:2] == UNIT_SHIFT && shift_dead) begin
            d = '0; e = 1'b1; lat = TMO + 1;
        end else begin
            d = ref_result(fun, x, y); e = 1'b0; lat = 3;
        end
        req_valid = 1'b1; req_fun = fun; req_a = x; req_b = y;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("req_accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        check("accept_only_when_idle", exp_q.size(), 0);
        exp_q.push_back({e, fun, d});
        acc_q.push_back(cyc + 1);
        lat_q.push_back(lat);
        @(negedge clk);
        req_valid = 1'b0;
        req_fun = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !rsp_valid) return;
            @(negedge clk);
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    int           en_cnt[4];
    logic         prev_valid, prev_pend, prev_hs;
    logic [W-1:0] prev_data;
    logic [3:0]   prev_fun;
    logic         prev_err;
    logic [20:0]  ent;
    int           acc_c, lat_c, en_tot;

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) en_cnt[k] = 0;
            prev_valid = 1'b0; prev_pend = 1'b0; prev_hs = 1'b0;
        end else begin
            en_cnt[0] += int'(ARITH_EN);
            en_cnt[1] += int'(LOGIC_EN);
            en_cnt[2] += int'(CMP_EN);
            en_cnt[3] += int'(SHIFT_EN);
            if (prev_hs) check("rsp_valid_drops_after_hs", rsp_valid, 0);
            if (rsp_valid && !prev_valid) begin
                if (acc_q.size() == 0) check("stale_rsp", 1, 0);
                else check("rsp_latency", cyc - acc_q[0], lat_q[0]);
            end
            if (rsp_valid && prev_pend) begin
                check("hold_data", rsp_data, prev_data);
                check("hold_fun", rsp_fun, prev_fun);
                check("hold_err", rsp_err, prev_err);
                check("hold_req_ready", req_ready, 0);
                check("hold_enables", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
                else begin
                    ent   = exp_q.pop_front();
                    acc_c = acc_q.pop_front();
                    lat_c = lat_q.pop_front();
                    en_tot = en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3];
                    check("rsp_data", rsp_data, ent[15:0]);
                    check("rsp_fun", rsp_fun, ent[19:16]);
                    check("rsp_err", rsp_err, ent[20]);
                    check("enable_pulses_total", en_tot, 1);
                    check("enable_pulse_selected", en_cnt[ent[19:18]], 1);
                end
                for (int k = 0; k < 4; k++) en_cnt[k] = 0;
            end
            prev_hs    = rsp_valid && rsp_ready;
            prev_valid = rsp_valid;
            prev_pend  = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_fun   = rsp_fun;
            prev_err   = rsp_err;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] f;
        @(negedge clk);
        @(negedge clk);
        // reset state
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_enables", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 0);
        check("reset_alu_fun", alu_fun, 0);
        check("reset_a_b", {a, b}, 0);
        check("reset_rsp", {rsp_data, rsp_fun, rsp_err}, 0);
        #1 rst = 1'b0;
        #1 check("req_ready_after_reset", req_ready, 1);
        @(negedge clk);

        // compare equal
        bp_cycles = 0;
        send(4'b1001, 16'h0005, 16'h0005);
        drain();
        // compare greater then less, back-to-back
        send(4'b1010, 16'd7, 16'd3);
        send(4'b1011, 16'd3, 16'd7);
        drain();
        // backpressure
        bp_cycles = 5;
        send(4'b1010, 16'd9, 16'd1);
        drain();
        bp_cycles = 0;
        // timeout on a silent shift unit
        shift_dead = 1'b1;
        send(4'b1100, 16'h00F0, 16'd2);
        drain();
        shift_dead = 1'b0;
        // unselected unit noise
        arith_noise = 1'b1;
        send(4'b1001, 16'd2, 16'd2);
        drain();
        arith_noise = 1'b0;

        // reset mid-operation (during WAIT)
        shift_dead = 1'b1;
        send(4'b1101, 16'h1234, 16'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_enables", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_alu_fun", alu_fun, 0);
        check("midrst_a_b", {a, b}, 0);
        exp_q.delete(); acc_q.delete(); lat_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        shift_dead = 1'b0;
        #1 check("req_ready_after_midrst", req_ready, 1);
        @(negedge clk);

        // random phase
        for (int n = 0; n < 40; n++) begin
            bp_cycles = $urandom_range(0, 2);
            f = 4'($urandom);
            if ($urandom_range(0, 1) == 0)
                send(f, 16'($urandom_range(0, 7)), 16'($urandom_range(0, 7)));
            else
                send(f, 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        // one timeout inside the random traffic context
        shift_dead = 1'b1;
        send(4'b1111, 16'($urandom), 16'($urandom));
        drain();
        shift_dead = 1'b0;
        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
